pcie_rx_lane_deskew: RTL
========================

Name: pcie_rx_lane_deskew

Overview:
- Per-lane symbol aligner, directly downstream of the PCIe PHY interface RX path, after 8b/10b decode.
- Buffers each lane's decoded symbols and finds the COM symbol (K28.5: data 8'hBC with K=1) on every enabled lane.
- Releases all lanes from per-lane read pointers so COMs leave on the same beat.
- Presents aligned symbol groups to the link-layer framer, monitors alignment while locked, and reports loss of lock.

Parameters:
- LANES, 8, number of lanes (1..16).
- DEPTH, 16, per-lane buffer entries; power of 2.
- MAX_SKEW, 8, maximum tolerated inter-lane skew in valid beats; must satisfy MAX_SKEW <= DEPTH-2.

Ports:
- clk_phy  in  1  PHY-domain clock; the only clock.
- rst_phy  in  1  synchronous reset, active-high.
- lane_en  in  LANES  enabled lanes for the negotiated width (x1/x4/x8).
- in_valid  in  1  beat valid; all lanes are sampled together.
- in_data  in  LANES*8  decoded symbols; lane i is bits [i*8+:8].
- in_k  in  LANES  K-symbol flag per lane.
- out_valid  out  1  aligned beat valid.
- out_data  out  LANES*8  aligned symbols.
- out_k  out  LANES  aligned K flags.
- deskew_locked  out  1  high while in LOCKED.
- deskew_err  out  1  one-cycle pulse on timeout or alignment loss.
- skew_obs  out  $clog2(MAX_SKEW+1)  skew in beats measured at the last lock.

Behaviour:
- Reset: all outputs 0, state SEARCH, wr_ptr=0, every com_seen bit cleared, memories need no reset. rst_phy asserted mid-operation aborts immediately to this state.
- Write side:
  - Every in_valid beat writes each lane's {k,data} to mem[lane][wr_ptr], and wr_ptr increments mod DEPTH.
  - No write occurs when in_valid=0.
  - Disabled lanes are still written but ignored everywhere else.
- COM(i) = in_valid & lane_en[i] & in_k[i] & (in_data[i] == 8'hBC).
- SEARCH:
  - If any COM(i) is seen: capture com_pos[i]=wr_ptr and set com_seen[i] for each such lane; skew_cnt=0.
  - If every enabled lane shows COM on the same beat, go directly to LOCKED with skew 0. Otherwise go to ALIGN.
- ALIGN:
  - skew_cnt increments on each in_valid beat. For each lane with COM(i) and !com_seen[i], capture com_pos[i]=wr_ptr.
  - Repeat COMs on lanes already seen are ignored.
  - When (com_seen | new COMs) covers lane_en: set rd_ptr[i]=com_pos[i] for all lanes, skew_obs=skew_cnt, go to LOCKED.
  - If skew_cnt reaches MAX_SKEW without full coverage: pulse deskew_err, clear com_seen, return to SEARCH.
  - Coverage and timeout on the same beat: coverage wins.
- LOCKED:
  - deskew_locked=1.
  - On each in_valid beat, read mem[i][rd_ptr[i]] for all lanes, increment every rd_ptr, and register the result to out_*.
  - out_valid=1 on the following cycle. Disabled lanes output data=0, k=0.
  - in_valid=0 means no read, no pointer motion, and out_valid=0 next cycle.
  - Latency from the lock beat: the first in_valid beat after the lock beat reads the aligned COMs, which appear on out_* one cycle later.
- Lock check: on each read beat, if any enabled lane reads COM and not all enabled lanes read COM:
  - that beat's out_valid=0;
  - deskew_err pulses;
  - deskew_locked falls next cycle;
  - com_seen is cleared and the block returns to SEARCH.
- Outside LOCKED: out_valid=0, and out_data/out_k hold their last values.
- lane_en change: any change from the previous cycle forces SEARCH and clears com_seen, with no deskew_err.
- lane_en=0: the block stays in SEARCH.
- Pointer arithmetic: all pointers are $clog2(DEPTH) bits and wrap naturally. wr_ptr - rd_ptr[i] never exceeds MAX_SKEW+1, so there is no overflow detection.

Test Plan:
- Zero skew, x8: COM on all lanes on beat 5, then incrementing data → deskew_locked rises after beat 5, skew_obs=0, out_* show 8×(K,BC) on the next read beat then the data in order, deskew_err never pulses.
- Skew 3, x4 (lane_en=4'hF): lane0 COM at beat 10, lane1 at 11, lane3 at 12, lane2 at 13 → lock after beat 13, skew_obs=3, and the first output beat shows COM on lanes 0–3 and zeros on lanes 4–7.
- Timeout, MAX_SKEW=8: lanes 0–6 see COM at beat 2 and lane 7 never does → deskew_err one-cycle pulse after 8 counted beats, state SEARCH, out_valid stays 0.
- Loss of lock: locked with skew 2, then inject COM on lane 5 only → that beat out_valid=0, deskew_err=1 for one cycle, deskew_locked=0 next cycle.
- Valid gaps: locked, in_valid toggling 1,0,0,1 → out_valid=1,0,0,1 delayed by one cycle, sequence preserved, and wrap past DEPTH=16 for 40 beats shows no corruption.
- Reset/lane_en: rst_phy asserted one cycle while LOCKED → all outputs 0 next cycle. lane_en changed 8'hFF→8'h0F while LOCKED → SEARCH with no deskew_err.

Source files
------------

// File: rtl/pcie_rx_lane_deskew_if.sv
// Lane-deskew bus: raw per-lane symbols from the PHY, aligned symbol groups to the framer.
interface pcie_rx_lane_deskew_if #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned MAX_SKEW = 8
);
  localparam int unsigned SW = $clog2(MAX_SKEW + 1);

  logic [LANES-1:0]   lane_en;
  logic               in_valid;
  logic [LANES*8-1:0] in_data;
  logic [LANES-1:0]   in_k;
  logic               out_valid;
  logic [LANES*8-1:0] out_data;
  logic [LANES-1:0]   out_k;
  logic               deskew_locked;
  logic               deskew_err;
  logic [SW-1:0]      skew_obs;

  modport master (
    output lane_en, in_valid, in_data, in_k,
    input  out_valid, out_data, out_k, deskew_locked, deskew_err, skew_obs
  );

  modport slave (
    input  lane_en, in_valid, in_data, in_k,
    output out_valid, out_data, out_k, deskew_locked, deskew_err, skew_obs
  );
endinterface

// File: rtl/pcie_rx_lane_deskew.sv
// Per-lane COM aligner: buffers decoded symbols per lane, locks read pointers on the
// COM of every enabled lane, streams aligned beats and drops lock on COM disagreement.
module pcie_rx_lane_deskew #(
  parameter int unsigned LANES    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned MAX_SKEW = 8
) (
  input logic                  clk_phy,
  input logic                  rst_phy,
  pcie_rx_lane_deskew_if.slave rx
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(MAX_SKEW + 1);
  localparam int unsigned DW = LANES * 8;
  localparam logic [7:0]  COM_SYM = 8'hBC;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LANES-1:0] com_seen_q, com_seen_d;
  logic [PW-1:0]    com_pos_q [LANES];
  logic [PW-1:0]    com_pos_d [LANES];
  logic [PW-1:0]    rd_ptr_q [LANES];
  logic [PW-1:0]    rd_ptr_d [LANES];
  logic [SW-1:0]    skew_cnt_q, skew_cnt_d;
  logic [LANES-1:0] lane_en_q;

  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [LANES-1:0] out_k_q, out_k_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [SW-1:0]    skew_obs_q, skew_obs_d;

  logic [8:0]       mem [LANES][DEPTH];

  logic [LANES-1:0] com_in;
  logic [LANES-1:0] com_rd;
  logic [DW-1:0]    rd_data;
  logic [LANES-1:0] rd_k;
  logic [LANES-1:0] cov;
  logic [SW-1:0]    cnt_inc;

  // Symbol store: every valid beat is written on all lanes, enabled or not
  always_ff @(posedge clk_phy) begin
    if (rx.in_valid) begin
      for (int i = 0; i < LANES; i++) begin
        mem[i][wr_ptr_q] <= {rx.in_k[i], rx.in_data[i*8 +: 8]};
      end
    end
  end

  // COM detection on the incoming beat and on the per-lane read ports
  always_comb begin
    rd_data = '0;
    rd_k    = '0;
    com_in  = '0;
    com_rd  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (rx.lane_en[i]) begin
        rd_k[i]            = mem[i][rd_ptr_q[i]][8];
        rd_data[i*8 +: 8]  = mem[i][rd_ptr_q[i]][7:0];
      end
      com_in[i] = rx.in_valid & rx.lane_en[i] & rx.in_k[i] & (rx.in_data[i*8 +: 8] == COM_SYM);
      com_rd[i] = rd_k[i] & (rd_data[i*8 +: 8] == COM_SYM);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    com_seen_d  = com_seen_q;
    com_pos_d   = com_pos_q;
    rd_ptr_d    = rd_ptr_q;
    skew_cnt_d  = skew_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_k_d     = out_k_q;
    err_d       = 1'b0;
    skew_obs_d  = skew_obs_q;
    cov         = com_seen_q | com_in;
    cnt_inc     = skew_cnt_q + SW'(1);

    if (rx.in_valid) wr_ptr_d = wr_ptr_q + PW'(1);

    // A width renegotiation invalidates any alignment silently
    if (rx.lane_en != lane_en_q) begin
      state_d    = SEARCH;
      com_seen_d = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (|com_in) begin
            com_seen_d = com_in;
            skew_cnt_d = '0;
            for (int i = 0; i < LANES; i++) begin
              if (com_in[i]) com_pos_d[i] = wr_ptr_q;
            end
            if (com_in == rx.lane_en) begin
              state_d    = LOCKED;
              skew_obs_d = '0;
              for (int i = 0; i < LANES; i++) rd_ptr_d[i] = wr_ptr_q;
            end else begin
              state_d = ALIGN;
            end
          end
        end
        ALIGN: begin
          if (rx.in_valid) begin
            skew_cnt_d = cnt_inc;
            com_seen_d = cov;
            for (int i = 0; i < LANES; i++) begin
              if (com_in[i] && !com_seen_q[i]) com_pos_d[i] = wr_ptr_q;
            end
            // Coverage takes priority over a timeout on the same beat
            if ((cov & rx.lane_en) == rx.lane_en) begin
              state_d    = LOCKED;
              skew_obs_d = cnt_inc;
              for (int i = 0; i < LANES; i++) rd_ptr_d[i] = com_pos_d[i];
            end else if (cnt_inc == SW'(MAX_SKEW)) begin
              state_d    = SEARCH;
              err_d      = 1'b1;
              com_seen_d = '0;
            end
          end
        end
        LOCKED: begin
          if (rx.in_valid) begin
            for (int i = 0; i < LANES; i++) rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
            if ((|com_rd) && (com_rd != rx.lane_en)) begin
              state_d    = SEARCH;
              err_d      = 1'b1;
              com_seen_d = '0;
            end else begin
              out_valid_d = 1'b1;
              out_data_d  = rd_data;
              out_k_d     = rd_k;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers
  always_ff @(posedge clk_phy) begin
    lane_en_q <= rx.lane_en;
    if (rst_phy) begin
      state_q     <= SEARCH;
      wr_ptr_q    <= '0;
      com_seen_q  <= '0;
      skew_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_k_q     <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      skew_obs_q  <= '0;
      for (int i = 0; i < LANES; i++) begin
        com_pos_q[i] <= '0;
        rd_ptr_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      com_seen_q  <= com_seen_d;
      skew_cnt_q  <= skew_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_k_q     <= out_k_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      skew_obs_q  <= skew_obs_d;
      com_pos_q   <= com_pos_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  assign rx.out_valid     = out_valid_q;
  assign rx.out_data      = out_data_q;
  assign rx.out_k         = out_k_q;
  assign rx.deskew_locked = locked_q;
  assign rx.deskew_err    = err_q;
  assign rx.skew_obs      = skew_obs_q;
endmodule
